// File: rtl/ca_source_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ca_source_sequencer: waveform ROM playback with rate divider, valid/ready |
// | output and back-pressure. Optional looping via SEQ_LOOP_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module ca_source_sequencer #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic              loop_i,
    input  logic [DIV_W-1:0]  rate_div_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_rd_en_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] smp_data_o,
    output logic              smp_valid_o,
    input  logic              smp_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic              cfg_err_o,
    output logic [15:0]       wrap_cnt_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d, rate_q, rate_d;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d, sa_q, sa_d, ea_q, ea_d;
    logic              last_q, last_d, land_q, land_d, valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d, cfg_err_q, cfg_err_d;
    logic              w_loop, w_run, w_tick, w_hold, w_rd, w_accept, w_done, w_busy, w_at_end;

`ifdef SEQ_LOOP_EN
    logic        loop_q, loop_d;
    logic [15:0] wrap_q, wrap_d;
    assign w_loop     = loop_q;
    assign wrap_cnt_o = wrap_q;
`else
    logic w_unused_loop;
    assign w_unused_loop = loop_i;
    assign w_loop        = 1'b0;
    assign wrap_cnt_o    = 16'd0;
`endif

    // Reads are gated by the output slot being free or freed this cycle, so a
    // landing sample never overwrites one the solver has not yet taken.
    assign w_busy   = (state_q != S_IDLE);
    assign w_run    = (state_q == S_RUN) && !pause_i && !stop_i;
    assign w_hold   = valid_q && !smp_ready_i;
    assign w_tick   = w_run && tick_q && !last_q;
    assign w_rd     = w_tick && !w_hold;
    assign w_accept = valid_q && smp_ready_i;
    assign w_done   = w_busy && !stop_i && last_q && w_accept;
    assign w_at_end = (addr_q == ea_q);

    assign rom_addr_o  = addr_q;
    assign rom_rd_en_o = w_rd;
    assign smp_data_o  = land_q ? rom_data_i : data_q;
    assign smp_valid_o = valid_q;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign overrun_o   = overrun_q;
    assign cfg_err_o   = cfg_err_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rate_d    = rate_q;
        tick_d    = tick_q;
        addr_d    = addr_q;
        sa_d      = sa_q;
        ea_d      = ea_q;
        last_d    = last_q;
        overrun_d = overrun_q;
        cfg_err_d = cfg_err_q;
        land_d    = w_rd;
        valid_d   = w_rd || w_hold;
        data_d    = land_q ? rom_data_i : data_q;
`ifdef SEQ_LOOP_EN
        loop_d    = loop_q;
        wrap_d    = wrap_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    if (start_addr_i <= end_addr_i) begin
                        state_d   = S_RUN;
                        rate_d    = (rate_div_i == '0) ? DIV_W'(1) : rate_div_i;
                        sa_d      = start_addr_i;
                        ea_d      = end_addr_i;
                        addr_d    = start_addr_i;
                        div_d     = '0;
                        tick_d    = 1'b0;
                        last_d    = 1'b0;
                        overrun_d = 1'b0;
                        cfg_err_d = 1'b0;
`ifdef SEQ_LOOP_EN
                        loop_d    = loop_i;
                        wrap_d    = 16'd0;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (pause_i) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!pause_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Divider phase 0 schedules a tick for the following cycle.
        if (w_run) begin
            tick_d = (div_q == '0);
            div_d  = (div_q == rate_q - DIV_W'(1)) ? '0 : div_q + DIV_W'(1);
        end
        if (w_tick && w_hold) begin
            overrun_d = 1'b1;
        end
        if (w_rd) begin
            if (w_at_end) begin
                if (w_loop) begin
                    addr_d = sa_q;
`ifdef SEQ_LOOP_EN
                    if (wrap_q != 16'hFFFF) begin
                        wrap_d = wrap_q + 16'd1;
                    end
`endif
                end else begin
                    last_d = 1'b1;
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (w_done) begin
            state_d = S_IDLE;
        end
        if (stop_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            land_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            rate_q    <= '0;
            tick_q    <= 1'b0;
            addr_q    <= '0;
            sa_q      <= '0;
            ea_q      <= '0;
            last_q    <= 1'b0;
            land_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_q    <= 1'b0;
            wrap_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            rate_q    <= rate_d;
            tick_q    <= tick_d;
            addr_q    <= addr_d;
            sa_q      <= sa_d;
            ea_q      <= ea_d;
            last_q    <= last_d;
            land_q    <= land_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            cfg_err_q <= cfg_err_d;
`ifdef SEQ_LOOP_EN
            loop_q    <= loop_d;
            wrap_q    <= wrap_d;
`endif
        end
    end
endmodule
`default_nettype wire
